// File: rtl/game_pkg.sv
// Shared whack-a-mole game constants and the button priority helper.
package game_pkg;
    localparam int N_BTN             = 8;
    localparam int IDX_W             = 3;
    // 10 ms of settling at 50 MHz
    localparam int DB_CYCLES_DEFAULT = 500000;

    // Lowest set bit wins; all-zero input yields 0.
    function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [N_BTN-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/btn_press_encoder_if.sv
// Button pins in, debounced levels and press events out.
interface btn_press_encoder_if;
    import game_pkg::*;

    logic [N_BTN-1:0] button;
    logic             enable;
    logic [N_BTN-1:0] btn_level;
    logic             press_valid;
    logic [IDX_W-1:0] press_idx;
    logic             press_multi;

    modport master (
        output button, enable,
        input  btn_level, press_valid, press_idx, press_multi
    );

    modport slave (
        input  button, enable,
        output btn_level, press_valid, press_idx, press_multi
    );
endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, optional inversion, and a
// counter that accepts a new level only after DB_CYCLES differing samples.
module btn_debounce #(
    parameter int DB_CYCLES = game_pkg::DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 20,
    parameter bit INVERT    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o
);
    logic [1:0]       sync_q;
    logic             samp;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Bring the raw pin into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], btn_i};
    end

    assign samp = sync_q[1] ^ INVERT;

    // Any sample matching the accepted level restarts the count
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (samp == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            stable_d = samp;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and accepted level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign level_o = stable_q;
endmodule

// File: rtl/btn_press_encoder.sv
// Debounces the player buttons and turns each new press into a one-cycle
// {press_valid, press_idx} event; simultaneous presses keep the lowest index.
module btn_press_encoder #(
    parameter int N_BTN      = 8,
    parameter int DB_CYCLES  = 500000,
    parameter int CNT_W      = 20,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                reset,
    btn_press_encoder_if.slave  bus
);
    import game_pkg::*;

    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] stable_dly_q;
    logic [N_BTN-1:0] rise;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             multi_q, multi_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W),
            .INVERT    (ACTIVE_LOW != 0)
        ) u_db (
            .clk     (clk),
            .rst     (reset),
            .btn_i   (bus.button[i]),
            .level_o (stable[i])
        );
    end

    assign rise = stable & ~stable_dly_q;

    // Press events: disabled presses are dropped, idx holds between events
    always_comb begin
        valid_d = bus.enable & (|rise);
        multi_d = bus.enable & (|(rise & (rise - N_BTN'(1))));
        idx_d   = idx_q;
        if (|rise) idx_d = lowest_set_idx(rise);
    end

    // Edge-detect delay and event register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_dly_q <= '0;
            valid_q      <= 1'b0;
            idx_q        <= '0;
            multi_q      <= 1'b0;
        end else begin
            stable_dly_q <= stable;
            valid_q      <= valid_d;
            idx_q        <= idx_d;
            multi_q      <= multi_d;
        end
    end

    assign bus.btn_level   = stable;
    assign bus.press_valid = valid_q;
    assign bus.press_idx   = idx_q;
    assign bus.press_multi = multi_q;
endmodule

// File: tb/tb_btn_press_encoder.sv
// Directed bench for btn_press_encoder with DB_CYCLES=4.
module tb_btn_press_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    btn_press_encoder_if bus ();

    btn_press_encoder #(
        .N_BTN      (8),
        .DB_CYCLES  (4),
        .CNT_W      (3),
        .ACTIVE_LOW (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Leaves time at posedge+1 with reset released; the next edge is edge 0.
    task automatic do_reset();
        reset      = 1'b1;
        bus.button = 8'h00;
        bus.enable = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.button = 8'h00;
        bus.enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.btn_level !== 8'h00 || bus.press_valid !== 1'b0 ||
            bus.press_idx !== 3'd0 || bus.press_multi !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got lvl=%h v=%b idx=%0d m=%b, exp 00/0/0/0",
                     bus.btn_level, bus.press_valid, bus.press_idx, bus.press_multi);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_press();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bus.button = 8'h20;
            @(posedge clk); #1;
            tests++;
            if (bus.btn_level !== ((c >= 5) ? 8'h20 : 8'h00)) begin
                fails++;
                $display("FAIL single_level c=%0d: got %h exp %h", c, bus.btn_level,
                         (c >= 5) ? 8'h20 : 8'h00);
            end
            tests++;
            if (bus.press_valid !== (c == 6)) begin
                fails++;
                $display("FAIL single_valid c=%0d: got %b exp %b", c, bus.press_valid, c == 6);
            end
            if (c == 6) begin
                tests++;
                if (bus.press_idx !== 3'd5 || bus.press_multi !== 1'b0) begin
                    fails++;
                    $display("FAIL single_idx: got idx=%0d m=%b exp idx=5 m=0",
                             bus.press_idx, bus.press_multi);
                end
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bus.button = (c < 3) ? 8'h04 : 8'h00;
            @(posedge clk); #1;
            tests++;
            if (bus.btn_level !== 8'h00 || bus.press_valid !== 1'b0) begin
                fails++;
                $display("FAIL glitch c=%0d: got lvl=%h v=%b exp 00/0", c,
                         bus.btn_level, bus.press_valid);
            end
        end
    endtask

    task automatic test_multi();
        int pulses;
        pulses = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bus.button = 8'h42;
            @(posedge clk); #1;
            if (bus.press_valid === 1'b1) pulses++;
            if (c == 6) begin
                tests++;
                if (bus.press_valid !== 1'b1 || bus.press_idx !== 3'd1 ||
                    bus.press_multi !== 1'b1) begin
                    fails++;
                    $display("FAIL multi_event: got v=%b idx=%0d m=%b exp 1/1/1",
                             bus.press_valid, bus.press_idx, bus.press_multi);
                end
            end
            if (c == 10) begin
                tests++;
                if (bus.btn_level !== 8'h42) begin
                    fails++;
                    $display("FAIL multi_level: got %h exp 42", bus.btn_level);
                end
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL multi_count: got %0d pulses exp 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int t_first;
        int t_second;
        pulses   = 0;
        t_first  = -1;
        t_second = -1;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            bus.button = (c < 10 || c >= 20) ? 8'h08 : 8'h00;
            @(posedge clk); #1;
            if (bus.press_valid === 1'b1) begin
                pulses++;
                if (t_first < 0) t_first = c;
                else             t_second = c;
                tests++;
                if (bus.press_idx !== 3'd3) begin
                    fails++;
                    $display("FAIL b2b_idx c=%0d: got %0d exp 3", c, bus.press_idx);
                end
            end
            if (c == 16) begin
                tests++;
                if (bus.btn_level !== 8'h00) begin
                    fails++;
                    $display("FAIL b2b_release: got %h exp 00", bus.btn_level);
                end
            end
        end
        tests++;
        if (pulses != 2 || t_first != 6 || t_second != 26) begin
            fails++;
            $display("FAIL b2b_timing: got n=%0d t1=%0d t2=%0d exp n=2 t1=6 t2=26",
                     pulses, t_first, t_second);
        end
    endtask

    task automatic test_enable();
        int pulses;
        pulses = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            bus.button = 8'h01;
            bus.enable = (c >= 10);
            @(posedge clk); #1;
            if (bus.press_valid === 1'b1) pulses++;
            if (c == 8) begin
                tests++;
                if (bus.btn_level !== 8'h01) begin
                    fails++;
                    $display("FAIL enable_level: got %h exp 01", bus.btn_level);
                end
            end
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL enable_suppress: got %0d pulses exp 0", pulses);
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            bus.button = 8'h10;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (bus.btn_level !== 8'h00 || bus.press_valid !== 1'b0 ||
                bus.press_idx !== 3'd0 || bus.press_multi !== 1'b0) begin
                fails++;
                $display("FAIL rst_hold c=%0d: got lvl=%h v=%b idx=%0d m=%b exp 00/0/0/0",
                         c, bus.btn_level, bus.press_valid, bus.press_idx, bus.press_multi);
            end
            if (c < 3) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            tests++;
            if (bus.press_valid !== (c == 6) ||
                bus.btn_level !== ((c >= 5) ? 8'h10 : 8'h00)) begin
                fails++;
                $display("FAIL rst_reaccept c=%0d: got v=%b lvl=%h exp v=%b lvl=%h", c,
                         bus.press_valid, bus.btn_level, c == 6,
                         (c >= 5) ? 8'h10 : 8'h00);
            end
            if (c == 6) begin
                tests++;
                if (bus.press_idx !== 3'd4) begin
                    fails++;
                    $display("FAIL rst_idx: got %0d exp 4", bus.press_idx);
                end
            end
        end
    endtask

    initial begin
        bus.button = 8'h00;
        bus.enable = 1'b1;
        test_reset();
        test_single_press();
        test_glitch();
        test_multi();
        test_back_to_back();
        test_enable();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/btn_press_encoder.md
Name: btn_press_encoder

Overview:
- Input-side counterpart to the LED/score display path of the whack-a-mole game.
- Conditions the 8 raw player buttons: synchronises, debounces and rising-edge detects each one.
- Encodes each new press into a single-cycle event {press_valid, press_idx} that the hit/score logic compares against the lit mole number.
- Sits between the board button pins and the game/score logic, in the same clock domain as the LFSR and the display driver.

Parameters:
- N_BTN, 8, number of buttons; must be 8 for the 3-bit index.
- DB_CYCLES, 500000, consecutive differing synced samples needed to accept a new level (10 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.
- ACTIVE_LOW, 0, when 1 the raw buttons are inverted immediately after synchronisation.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- button  input  8  raw, asynchronous button pins
- enable  input  1  when 0, press events are suppressed; debouncing keeps running
- btn_level  output  8  debounced, polarity-corrected button levels
- press_valid  output  1  one-cycle pulse for a newly accepted press
- press_idx  output  3  index of the pressed button; valid only while press_valid=1
- press_multi  output  1  one-cycle pulse, same cycle as press_valid, when more than one button was accepted as pressed on the same edge

Behaviour:
- Single clock, clk. Reset is asynchronous and active-high.
- Reset values: all sync flops 0; all counters 0; btn_level 8'h00; press_valid 0; press_idx 3'd0; press_multi 0.
- Synchroniser: 2-flop synchroniser per bit, followed by optional inversion (ACTIVE_LOW).
- Debounce, per channel, with registered level stable[i]:
  - If sync[i] == stable[i], the counter clears to 0.
  - Otherwise the counter increments.
  - On the DB_CYCLES-th consecutive differing sample, stable[i] takes sync[i] and the counter clears.
  - Any sample equal to stable[i] before that point restarts the count, so glitches shorter than DB_CYCLES cycles are ignored.
- Edge detect: rise[i] = stable[i] & ~stable_d[i], where stable_d is stable delayed by one cycle. Release edges produce no event.
- Event register, updated every cycle:
  - press_valid <= enable & |rise.
  - press_idx <= lowest set index in rise when |rise; otherwise it holds its previous value.
  - press_multi <= enable & (popcount(rise) > 1).
  - Higher-index simultaneous presses are dropped, not queued.
- Latency: a raw change that stays stable from clock edge k onward asserts press_valid in the cycle following edge k+DB_CYCLES+2. btn_level changes one cycle earlier.
- A held button produces exactly one press_valid. A new event requires a debounced release followed by a new debounced press.
- enable=0 while rise is set: the event is lost, not deferred. btn_level still updates.
- Reset asserted mid-debounce: counters and levels return to their reset values immediately. A button held through reset is then re-accepted after DB_CYCLES+2 cycles and produces one press_valid.
- DB_CYCLES=1 is legal: each level change is accepted on the first differing sample.

Decomposition:
- Shared package game_pkg holds:
  - N_BTN = 8
  - IDX_W = 3
  - the debounce default constant
  - a function lowest_set_idx(8-bit) -> 3-bit, reused by the game logic.
- Sub-module btn_debounce: a single channel containing the sync, counter and stable register; parameters DB_CYCLES and CNT_W.
- btn_press_encoder instantiates btn_debounce N_BTN times and adds the edge detect, priority encoder and event register.

Test Plan:
All scenarios run with DB_CYCLES=4, ACTIVE_LOW=0, enable=1 unless stated otherwise.
1. Hold button[5]=1 from edge 0 for 20 cycles -> btn_level[5] rises after edge 5; press_valid=1 for exactly one cycle after edge 6 with press_idx=5 and press_multi=0; no further events while held.
2. Pulse button[2]=1 for 3 cycles, then 0 -> btn_level stays 8'h00 and press_valid is never asserted.
3. Assert button[1] and button[6] on the same edge and hold -> one press_valid with press_idx=1 and press_multi=1; no event for button 6.
4. Press button[3], release for 10 cycles, press again -> two press_valid pulses, both with press_idx=3, separated by at least 2*DB_CYCLES cycles.
5. Drive enable=0 during the rise of button[0] -> btn_level[0]=1 and no press_valid; raising enable later with the button still held produces no event.
6. Assert reset while button[4] is held at counter value 2, then release reset with the button still held -> outputs are 0 during reset; one press_valid with press_idx=4 occurs DB_CYCLES+2 cycles after reset deassertion.
